// File: rtl/led_pkg.sv
// Shared constants and pattern helpers for the LED pattern sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ALL_ON   = 2'b00,
        MODE_RUN      = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_BLINK    = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [7:0] LED_OFF    = 8'hFF;
    localparam logic [7:0] LED_ALL_ON = 8'h00;

    // Active-low one-hot: the single LED at position pos is lit.
    function automatic logic [7:0] pos_to_led(input logic [2:0] pos);
        return ~(8'h01 << pos);
    endfunction

    function automatic logic [7:0] init_pattern(input logic [1:0] mode);
        logic [7:0] pat;
        case (mode)
            MODE_ALL_ON:   pat = LED_ALL_ON;
            MODE_RUN:      pat = pos_to_led(3'd0);
            MODE_PINGPONG: pat = pos_to_led(3'd0);
            MODE_BLINK:    pat = LED_ALL_ON;
            default:       pat = LED_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 and flags the terminal count while enabled.
module led_prescaler #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_s;

    // Terminal count qualified by enable, so a paused counter never ticks.
    always_comb begin
        tick_s = (cnt_r == CNT_MAX) && en;
    end

    // Counter register; clear wins over counting, disable holds the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = tick_s;

endmodule

// File: rtl/led_pattern_seq.sv
// Timed, mode-selectable pattern sequencer driving the active-low LED bus.
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       pause,
    output logic [7:0] led,
    output logic       step_tick
);

    logic [1:0] mode_q_r;
    logic [2:0] pos_r;
    dir_e       dir_r;
    logic       phase_r;
    logic [7:0] led_r;
    logic       step_tick_r;

    logic [2:0] pos_nx_s;
    dir_e       dir_nx_s;
    logic       phase_nx_s;
    logic [7:0] led_nx_s;
    logic       step_nx_s;
    logic       reload_s;
    logic       tick_s;

    assign reload_s = (mode != mode_q_r);

    led_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (reload_s),
        .en   (~pause),
        .tick (tick_s)
    );

    // Next pattern state: reload beats a coincident tick; otherwise step or hold.
    always_comb begin
        pos_nx_s   = pos_r;
        dir_nx_s   = dir_r;
        phase_nx_s = phase_r;
        led_nx_s   = led_r;
        step_nx_s  = 1'b0;
        if (reload_s) begin
            pos_nx_s   = 3'd0;
            dir_nx_s   = DIR_LEFT;
            phase_nx_s = 1'b0;
            led_nx_s   = init_pattern(mode);
            step_nx_s  = 1'b0;
        end else if (tick_s) begin
            step_nx_s = 1'b1;
            case (mode)
                MODE_ALL_ON: begin
                    led_nx_s = LED_ALL_ON;
                end
                MODE_RUN: begin
                    pos_nx_s = pos_r + 3'd1;
                    led_nx_s = pos_to_led(pos_nx_s);
                end
                MODE_PINGPONG: begin
                    // Direction flips on the edge that reaches an end, so each end shows once.
                    if (dir_r == DIR_LEFT) begin
                        pos_nx_s = pos_r + 3'd1;
                        if (pos_nx_s == 3'd7) begin
                            dir_nx_s = DIR_RIGHT;
                        end else begin
                            dir_nx_s = DIR_LEFT;
                        end
                    end else begin
                        pos_nx_s = pos_r - 3'd1;
                        if (pos_nx_s == 3'd0) begin
                            dir_nx_s = DIR_LEFT;
                        end else begin
                            dir_nx_s = DIR_RIGHT;
                        end
                    end
                    led_nx_s = pos_to_led(pos_nx_s);
                end
                MODE_BLINK: begin
                    phase_nx_s = ~phase_r;
                    if (phase_nx_s) begin
                        led_nx_s = LED_OFF;
                    end else begin
                        led_nx_s = LED_ALL_ON;
                    end
                end
                default: begin
                    led_nx_s = LED_OFF;
                end
            endcase
        end else begin
            step_nx_s = 1'b0;
        end
    end

    // State and output registers; mode_q tracks mode during reset to avoid a reload after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q_r    <= mode;
            pos_r       <= 3'd0;
            dir_r       <= DIR_LEFT;
            phase_r     <= 1'b0;
            led_r       <= LED_OFF;
            step_tick_r <= 1'b0;
        end else begin
            mode_q_r    <= mode;
            pos_r       <= pos_nx_s;
            dir_r       <= dir_nx_s;
            phase_r     <= phase_nx_s;
            led_r       <= led_nx_s;
            step_tick_r <= step_nx_s;
        end
    end

    assign led       = led_r;
    assign step_tick = step_tick_r;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq with TICK_DIV = 4.
module tb_led_pattern_seq;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       pause;
    logic [7:0] led;
    logic       step_tick;

    always #5 clk = ~clk;

    led_pattern_seq #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .pause     (pause),
        .led       (led),
        .step_tick (step_tick)
    );

    typedef struct packed {
        logic [7:0] led;
        logic       st;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int prev_st_cyc = -1;
    int last_gap = -1;

    // Reference model state: step index instead of position/direction registers.
    int         m_cnt = 0;
    int         m_idx = 0;
    bit         m_phase = 1'b0;
    logic [7:0] m_led = 8'hFF;
    bit         m_st = 1'b0;
    logic [1:0] m_modeq = 2'b00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] run_led(input int p);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << p);
    endfunction

    task automatic model_edge();
        int k;
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_phase = 1'b0; m_led = 8'hFF; m_st = 1'b0;
        end else if (mode !== m_modeq) begin
            m_cnt = 0; m_idx = 0; m_phase = 1'b0; m_st = 1'b0;
            m_led = (mode == 2'b01 || mode == 2'b10) ? 8'hFE : 8'h00;
        end else if (pause) begin
            m_st = 1'b0;
        end else if (m_cnt == TD - 1) begin
            m_cnt = 0;
            m_st  = 1'b1;
            m_idx++;
            case (mode)
                2'b00: m_led = 8'h00;
                2'b01: m_led = run_led(m_idx % 8);
                2'b10: begin
                    k = m_idx % 14;
                    m_led = run_led((k <= 7) ? k : 14 - k);
                end
                default: begin
                    m_phase = ~m_phase;
                    m_led = m_phase ? 8'hFF : 8'h00;
                end
            endcase
        end else begin
            m_cnt++;
            m_st = 1'b0;
        end
        m_modeq = mode;
    endtask

    task automatic cycle();
        exp_t e;
        exp_t p;
        @(posedge clk);
        model_edge();
        e.led = m_led;
        e.st  = m_st;
        exp_q.push_back(e);
        @(negedge clk);
        cyc++;
        p = exp_q.pop_front();
        check_val("led", {24'h0, led}, {24'h0, p.led});
        check_val("step_tick", {31'h0, step_tick}, {31'h0, p.st});
        if (step_tick === 1'b1) begin
            if (prev_st_cyc >= 0) last_gap = cyc - prev_st_cyc;
            prev_st_cyc = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit got;
        rst = 1'b1;
        mode = 2'b01;
        pause = 1'b0;
        @(negedge clk);
        run(3);
        rst = 1'b0;
        run(44);                       // running light incl. wrap to FE
        mode = 2'b10;
        run(62);                       // ping-pong, both ends
        rst = 1'b1; mode = 2'b11;
        run(2);
        rst = 1'b0;
        run(20);                       // blink from reset
        mode = 2'b00;
        run(12);                       // all-on still ticks
        mode = 2'b01;
        run(6);

        // Pause 10 cycles mid-period: expect a 14-cycle step gap.
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            cycle();
            if (step_tick === 1'b1) got = 1'b1;
        end
        check_val("tick_before_pause", {31'h0, got}, 32'd1);
        run(2);
        pause = 1'b1;
        run(10);
        pause = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (step_tick === 1'b1) got = 1'b1;
        end
        check_val("tick_after_pause", {31'h0, got}, 32'd1);
        check_val("pause_gap", last_gap, 32'd14);

        // Mode change on the tick edge.
        for (int i = 0; i < TD && m_cnt != TD - 1; i++) cycle();
        mode = 2'b10;
        run(8);

        // Mode change while paused.
        mode = 2'b01;
        run(5);
        pause = 1'b1;
        run(2);
        mode = 2'b10;
        run(3);
        pause = 1'b0;
        run(10);

        // One-cycle reset mid-pattern.
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
